// File: rtl/mem_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_responder
// Description : In-order request/response memory model with fixed per-type
//               latency. Optional `MEMRSP_STATS_EN adds traffic statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_responder #(
    parameter int QUEUE_DEPTH   = 64,
    parameter int READ_LATENCY  = 20,
    parameter int WRITE_LATENCY = 12,
    parameter int INIT_CYCLES   = 8,
    parameter int TS_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic [63:0]                    req_addr,
    input  logic                           req_type,
    input  logic [31:0]                    req_source_id,
    output logic                           req_ready,
    output logic                           resp_valid,
    output logic [63:0]                    resp_addr,
    output logic                           init_done
`ifdef MEMRSP_STATS_EN
    ,
    output logic [31:0]                    stat_rd_acc,
    output logic [31:0]                    stat_wr_acc,
    output logic [31:0]                    stat_reject,
    output logic [$clog2(QUEUE_DEPTH):0]   stat_max_occ
`endif
);

    localparam int                  c_ptr_w     = $clog2(QUEUE_DEPTH);
    localparam int                  c_init_w    = $clog2(INIT_CYCLES + 1);
    localparam logic [c_ptr_w:0]    c_depth     = (c_ptr_w + 1)'(QUEUE_DEPTH);
    localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYCLES - 1);
    localparam logic [TS_W-1:0]     c_rd_lat    = TS_W'(READ_LATENCY);
    localparam logic [TS_W-1:0]     c_wr_lat    = TS_W'(WRITE_LATENCY);
    localparam logic [TS_W-1:0]     c_ts_one    = TS_W'(1);
    localparam logic [TS_W-1:0]     c_ts_half   = TS_W'(1) << (TS_W - 1);

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]          r_state, w_state_nxt;
    logic [c_init_w-1:0] r_init_cnt, w_init_cnt_nxt;
    logic [TS_W-1:0]     r_now;
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]    r_occ, w_occ_nxt;
    logic                r_req_ready, r_resp_valid;
    logic [63:0]         r_resp_addr;

    // Only address and due time have a consumer; type is folded into due.
    logic [63:0]         r_addr_mem [QUEUE_DEPTH];
    logic [TS_W-1:0]     r_due_mem  [QUEUE_DEPTH];

    logic                w_run, w_accept, w_pop, w_due_reached;
    logic [TS_W-1:0]     w_head_due, w_lat;
    logic                w_unused_id;

    assign w_unused_id = ^req_source_id;

    // Init FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_init;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            c_st_init: begin
                if (r_init_cnt == c_init_last) w_state_nxt = c_st_run;
                else                           w_init_cnt_nxt = r_init_cnt + c_init_w'(1);
            end
            c_st_run: ;
            default:  w_state_nxt = c_st_init;
        endcase
    end

    assign w_run      = (r_state == c_st_run);
    assign w_head_due = r_due_mem[r_rd_ptr];
    assign w_lat      = req_type ? c_wr_lat : c_rd_lat;
    // Unsigned modular age below half the range == signed(now - due) >= 0
    assign w_due_reached = (r_now - w_head_due) < c_ts_half;
    assign w_pop         = (r_occ != '0) && w_due_reached;
    assign w_accept      = req_valid && w_run && (r_occ < c_depth);

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_accept && !w_pop)      w_occ_nxt = r_occ + (c_ptr_w + 1)'(1);
        else if (!w_accept && w_pop) w_occ_nxt = r_occ - (c_ptr_w + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_now        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_addr  <= '0;
        end else begin
            if (w_run) r_now <= r_now + c_ts_one;
            if (w_accept) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + c_ptr_w'(1);
                r_resp_addr <= r_addr_mem[r_rd_ptr];
            end
            r_occ        <= w_occ_nxt;
            r_req_ready  <= w_accept;
            r_resp_valid <= w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_mem[r_wr_ptr] <= req_addr;
            r_due_mem[r_wr_ptr]  <= r_now + w_lat;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_addr  = r_resp_addr;
    assign init_done  = w_run;

`ifdef MEMRSP_STATS_EN
    logic [31:0]      r_stat_rd, r_stat_wr, r_stat_rej;
    logic [c_ptr_w:0] r_stat_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_rej <= '0;
            r_stat_max <= '0;
        end else begin
            if (w_accept && !req_type && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 32'd1;
            if (w_accept && req_type && (r_stat_wr != '1))  r_stat_wr <= r_stat_wr + 32'd1;
            if (req_valid && w_run && !w_accept && (r_stat_rej != '1))
                r_stat_rej <= r_stat_rej + 32'd1;
            if (w_occ_nxt > r_stat_max) r_stat_max <= w_occ_nxt;
        end
    end

    assign stat_rd_acc  = r_stat_rd;
    assign stat_wr_acc  = r_stat_wr;
    assign stat_reject  = r_stat_rej;
    assign stat_max_occ = r_stat_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_responder
// Description : Self-checking bench: random and directed traffic compared
//               cycle by cycle against an absolute-time queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_responder;

    localparam int DEPTH   = 16;
    localparam int RD_LAT  = 20;
    localparam int WR_LAT  = 12;
    localparam int INIT    = 8;
    localparam int TS_W    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_type;
    logic [31:0] req_source_id;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_addr;
    logic        init_done;
`ifdef MEMRSP_STATS_EN
    logic [31:0]              stat_rd_acc, stat_wr_acc, stat_reject;
    logic [$clog2(DEPTH):0]   stat_max_occ;
`endif

    mem_req_responder #(
        .QUEUE_DEPTH  (DEPTH),
        .READ_LATENCY (RD_LAT),
        .WRITE_LATENCY(WR_LAT),
        .INIT_CYCLES  (INIT),
        .TS_W         (TS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_type     (req_type),
        .req_source_id(req_source_id),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_addr    (resp_addr),
        .init_done    (init_done)
`ifdef MEMRSP_STATS_EN
        ,
        .stat_rd_acc  (stat_rd_acc),
        .stat_wr_acc  (stat_wr_acc),
        .stat_reject  (stat_reject),
        .stat_max_occ (stat_max_occ)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: entries carry an absolute (non-wrapping) due cycle.
    typedef struct {
        logic [63:0] addr;
        longint      due;
    } ent_t;

    ent_t        m_q[$];
    longint      m_t;
    int          m_init_cnt;
    bit          m_init_done;
    bit          m_ready;
    bit          m_resp_valid;
    logic [63:0] m_resp_addr;
    int          m_accepted;
    int          n_resp_seen;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_q.delete();
        m_t          = 0;
        m_init_cnt   = 0;
        m_init_done  = 0;
        m_ready      = 0;
        m_resp_valid = 0;
        m_resp_addr  = '0;
        m_accepted   = 0;
        n_resp_seen  = 0;
    endtask

    task automatic model_step(input bit v, input logic [63:0] a, input bit ty);
        bit pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop     = m_init_done && (m_q.size() > 0) && (m_q[0].due <= m_t);
        m_ready = v && m_init_done && (m_q.size() < DEPTH);
        if (pop) begin
            m_resp_valid = 1;
            m_resp_addr  = m_q[0].addr;
            void'(m_q.pop_front());
        end else begin
            m_resp_valid = 0;
        end
        if (m_ready) begin
            m_q.push_back('{addr: a, due: m_t + (ty ? WR_LAT : RD_LAT)});
            m_accepted++;
        end
        if (m_init_done) begin
            m_t++;
        end else begin
            m_init_cnt++;
            if (m_init_cnt == INIT) m_init_done = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s @%0t: observed %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req_ready",  {63'd0, req_ready},  {63'd0, m_ready});
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_resp_valid});
        chk("resp_addr",  resp_addr,           m_resp_addr);
        chk("init_done",  {63'd0, init_done},  {63'd0, m_init_done});
        if (resp_valid === 1'b1) n_resp_seen++;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit v, input logic [63:0] a, input bit ty);
        req_valid     = v;
        req_addr      = a;
        req_type      = ty;
        req_source_id = $urandom;
        @(posedge clk);
        model_step(v, a, ty);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_type      = 1'b0;
        req_source_id = '0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        cycle(0, '0, 0);
        cycle(1, rnd64(), 0);

        // Init window: offers must be ignored until init_done rises
        rst_n = 1'b1;
        for (int i = 0; i < INIT + 2; i++) cycle(1, rnd64(), 1'($urandom_range(0, 1)));
        chk("init_len", 64'(m_init_cnt), 64'(INIT));

        // Drain what the post-init offers queued, then a single read
        repeat (30) cycle(0, rnd64(), 0);
        cycle(1, 64'h40, 0);
        repeat (RD_LAT + 5) cycle(0, rnd64(), 0);

        // Stream of 128 requests, every 4th a write, retried until accepted
        for (int i = 0; i < 128; i++) begin
            done = 0;
            for (int k = 0; k < 200 && !done; k++) begin
                cycle(1, 64'(i) * 64'h40, (i % 4) == 3);
                done = m_ready;
            end
            if (!done) chk("accept_timeout", 64'd0, 64'd1);
            repeat ($urandom_range(0, 2)) cycle(0, rnd64(), 0);
        end
        repeat (DEPTH * RD_LAT + 10) begin
            if (m_q.size() == 0) break;
            cycle(0, rnd64(), 0);
        end
        repeat (3) cycle(0, rnd64(), 0);
        chk("resp_count", 64'(n_resp_seen), 64'(m_accepted));

        // Full queue with a held offer
        for (int i = 0; i < DEPTH + RD_LAT + 4; i++) cycle(1, 64'h1000 + 64'(i), 0);
        repeat (DEPTH + RD_LAT + 5) cycle(0, rnd64(), 0);

        // Head-of-line: read then a write that is due earlier
        cycle(1, 64'hAAAA_0000, 0);
        cycle(1, 64'hBBBB_0000, 1);
        repeat (RD_LAT + 5) cycle(0, rnd64(), 0);

        // Reset with traffic in flight
        for (int i = 0; i < 10; i++) cycle(1, rnd64(), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        cycle(1, rnd64(), 0);
        rst_n = 1'b1;
        repeat (INIT + RD_LAT + 10) cycle(0, rnd64(), 0);

        // Random traffic long enough to wrap the timestamp several times
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 2) != 0), rnd64(), 1'($urandom_range(0, 1)));
        repeat (DEPTH * RD_LAT + 10) begin
            if (m_q.size() == 0) break;
            cycle(0, rnd64(), 0);
        end
        repeat (3) cycle(0, rnd64(), 0);
        chk("resp_count_final", 64'(n_resp_seen), 64'(m_accepted));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
